// File: rtl/qpu_exu_alu_wbck_pkg.sv
// Shared widths and writeback entry layout for the ALU/long-pipe commit stage.
// The entry is packed as {is_time, rdidx, wdat} so the FIFO can hold it as a flat word.
package qpu_exu_alu_wbck_pkg;

  localparam int QPU_XLEN        = 32;
  localparam int QPU_TIME_WIDTH  = 10;
  localparam int QPU_RFIDX_WIDTH = 5;
  localparam int WBCK_DEPTH      = 2;
  localparam int WBCK_STARVE_MAX = 4;

  typedef struct packed {
    logic                       is_time;
    logic [QPU_RFIDX_WIDTH-1:0] rdidx;
    logic [QPU_XLEN-1:0]        wdat;
  } wbck_entry_t;

  localparam int WBCK_ENTRY_W = $bits(wbck_entry_t);

  // Time register only keeps the low bits; anything above is discarded.
  function automatic logic [QPU_TIME_WIDTH-1:0] wbck_to_time(input logic [QPU_XLEN-1:0] wdat);
    return wdat[QPU_TIME_WIDTH-1:0];
  endfunction

  function automatic logic wbck_rf_en(input logic [QPU_RFIDX_WIDTH-1:0] rdidx);
    return (rdidx != {QPU_RFIDX_WIDTH{1'b0}});
  endfunction

endpackage

// File: rtl/qpu_exu_alu_wbck_if.sv
// Valid/ready writeback handshake carrying one result and its destination.
// The long-pipe side has no time-register destination, hence its own modport.
interface qpu_exu_alu_wbck_if;
  import qpu_exu_alu_wbck_pkg::*;

  logic                       valid;
  logic                       ready;
  logic [QPU_XLEN-1:0]        wdat;
  logic [QPU_RFIDX_WIDTH-1:0] rdidx;
  logic                       is_time;

  modport master (
    output valid,
    output wdat,
    output rdidx,
    output is_time,
    input  ready
  );

  modport slave (
    input  valid,
    input  wdat,
    input  rdidx,
    input  is_time,
    output ready
  );

  modport lng_slave (
    input  valid,
    input  wdat,
    input  rdidx,
    output ready
  );

endinterface

// File: rtl/qpu_exu_alu_wbck_fifo.sv
// Generic synchronous FIFO: power-of-two depth, wrapping pointers plus an occupancy count.
// Push while full and pop while empty are ignored.
module qpu_wbck_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdat_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdat_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    rd_ptr_d;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             push_s;
  logic             pop_s;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == {CW{1'b0}});
  assign count_o = count_q;
  assign push_s  = push_i & ~full_o;
  assign pop_s   = pop_i & ~empty_o;
  assign rdat_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1'b1);
      2'b01:   count_d = count_q - CW'(1'b1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is datapath only; validity is tracked by count/pointers.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wdat_i;
    end
  end

endmodule

// File: rtl/qpu_exu_alu_wbck.sv
// Commit stage for ALU results: buffers them, arbitrates the single write slot against the
// long pipe (long wins, ALU forced through after STARVE_MAX losses) and registers the write.
module qpu_exu_alu_wbck
  import qpu_exu_alu_wbck_pkg::*;
#(
  parameter int DEPTH      = WBCK_DEPTH,
  parameter int STARVE_MAX = WBCK_STARVE_MAX
) (
  input  logic                         clk,
  input  logic                         rst,
  qpu_exu_alu_wbck_if.slave            alu_wbck_i,
  qpu_exu_alu_wbck_if.lng_slave        lng_wbck_i,
  output logic                         rf_wbck_o_ena,
  output logic [QPU_RFIDX_WIDTH-1:0]   rf_wbck_o_rdidx,
  output logic [QPU_XLEN-1:0]          rf_wbck_o_wdat,
  output logic                         time_wbck_o_ena,
  output logic [QPU_TIME_WIDTH-1:0]    time_wbck_o_wdat,
  output logic                         wbck_o_pend
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int CW = $clog2(DEPTH) + 1;

  wbck_entry_t                 push_ent_s;
  wbck_entry_t                 head_s;
  logic [WBCK_ENTRY_W-1:0]     head_raw_s;
  logic                        fifo_full_s;
  logic                        fifo_empty_s;
  logic [CW-1:0]               fifo_count_s;
  logic                        fifo_push_s;
  logic                        fifo_pop_s;
  logic                        force_alu_s;
  logic                        lng_win_s;

  logic [SW-1:0]               starve_cnt_q;
  logic [SW-1:0]               starve_cnt_d;
  logic                        rf_ena_q;
  logic                        rf_ena_d;
  logic [QPU_RFIDX_WIDTH-1:0]  rf_rdidx_q;
  logic [QPU_RFIDX_WIDTH-1:0]  rf_rdidx_d;
  logic [QPU_XLEN-1:0]         rf_wdat_q;
  logic [QPU_XLEN-1:0]         rf_wdat_d;
  logic                        time_ena_q;
  logic                        time_ena_d;
  logic [QPU_TIME_WIDTH-1:0]   time_wdat_q;
  logic [QPU_TIME_WIDTH-1:0]   time_wdat_d;

  // Ready depends only on registered occupancy, never on any valid.
  assign alu_wbck_i.ready = ~fifo_full_s;
  assign fifo_push_s      = alu_wbck_i.valid & ~fifo_full_s;
  assign push_ent_s       = '{is_time: alu_wbck_i.is_time,
                              rdidx:   alu_wbck_i.rdidx,
                              wdat:    alu_wbck_i.wdat};
  assign head_s           = wbck_entry_t'(head_raw_s);

  qpu_wbck_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WBCK_ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push_s),
    .wdat_i  (push_ent_s),
    .pop_i   (fifo_pop_s),
    .rdat_o  (head_raw_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

  assign force_alu_s      = (starve_cnt_q == SW'(STARVE_MAX)) & ~fifo_empty_s;
  assign lng_wbck_i.ready = ~force_alu_s;
  assign lng_win_s        = lng_wbck_i.valid & ~force_alu_s;
  assign fifo_pop_s       = ~lng_win_s & ~fifo_empty_s;
  assign wbck_o_pend      = (fifo_count_s != {CW{1'b0}});

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (fifo_pop_s || fifo_empty_s) begin
      starve_cnt_d = {SW{1'b0}};
    end else if (lng_win_s && (starve_cnt_q != SW'(STARVE_MAX))) begin
      starve_cnt_d = starve_cnt_q + SW'(1'b1);
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  // Index 0 is the hardwired zero register: the slot is used but nothing is written.
  always_comb begin
    rf_ena_d    = 1'b0;
    rf_rdidx_d  = {QPU_RFIDX_WIDTH{1'b0}};
    rf_wdat_d   = {QPU_XLEN{1'b0}};
    time_ena_d  = 1'b0;
    time_wdat_d = {QPU_TIME_WIDTH{1'b0}};
    if (lng_win_s) begin
      rf_ena_d   = wbck_rf_en(lng_wbck_i.rdidx);
      rf_rdidx_d = lng_wbck_i.rdidx;
      rf_wdat_d  = lng_wbck_i.wdat;
    end else if (fifo_pop_s) begin
      if (head_s.is_time) begin
        time_ena_d  = 1'b1;
        time_wdat_d = wbck_to_time(head_s.wdat);
      end else begin
        rf_ena_d   = wbck_rf_en(head_s.rdidx);
        rf_rdidx_d = head_s.rdidx;
        rf_wdat_d  = head_s.wdat;
      end
    end else begin
      rf_ena_d   = 1'b0;
      time_ena_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= {SW{1'b0}};
      rf_ena_q     <= 1'b0;
      rf_rdidx_q   <= {QPU_RFIDX_WIDTH{1'b0}};
      rf_wdat_q    <= {QPU_XLEN{1'b0}};
      time_ena_q   <= 1'b0;
      time_wdat_q  <= {QPU_TIME_WIDTH{1'b0}};
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rf_ena_q     <= rf_ena_d;
      rf_rdidx_q   <= rf_rdidx_d;
      rf_wdat_q    <= rf_wdat_d;
      time_ena_q   <= time_ena_d;
      time_wdat_q  <= time_wdat_d;
    end
  end

  assign rf_wbck_o_ena    = rf_ena_q;
  assign rf_wbck_o_rdidx  = rf_rdidx_q;
  assign rf_wbck_o_wdat   = rf_wdat_q;
  assign time_wbck_o_ena  = time_ena_q;
  assign time_wbck_o_wdat = time_wdat_q;

endmodule

// File: tb/tb_qpu_exu_alu_wbck.sv
// Bench for qpu_exu_alu_wbck: directed vector table, hand-written corner sequences and
// randomized traffic, all scored against a queue-based reference model.
module tb_qpu_exu_alu_wbck;
  import qpu_exu_alu_wbck_pkg::*;

  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rf_ena;
  logic [4:0]  rf_rdidx;
  logic [31:0] rf_wdat;
  logic        time_ena;
  logic [9:0]  time_wdat;
  logic        pend;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  qpu_exu_alu_wbck_if alu_if ();
  qpu_exu_alu_wbck_if lng_if ();

  qpu_exu_alu_wbck #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk              (clk),
    .rst              (rst),
    .alu_wbck_i       (alu_if.slave),
    .lng_wbck_i       (lng_if.lng_slave),
    .rf_wbck_o_ena    (rf_ena),
    .rf_wbck_o_rdidx  (rf_rdidx),
    .rf_wbck_o_wdat   (rf_wdat),
    .time_wbck_o_ena  (time_ena),
    .time_wbck_o_wdat (time_wdat),
    .wbck_o_pend      (pend)
  );

  // Reference model: list of buffered results plus the count of consecutive long-pipe wins.
  typedef struct {
    logic [31:0] wdat;
    logic [4:0]  rdidx;
    logic        is_time;
  } ent_t;
  ent_t mq[$];
  int   m_starve;

  typedef struct {
    logic [31:0] wdat;
    logic [4:0]  rdidx;
    logic        is_time;
    logic        exp_rf_ena;
    logic [4:0]  exp_rdidx;
    logic [31:0] exp_rf_wdat;
    logic        exp_time_ena;
    logic [9:0]  exp_time_wdat;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: check ready/pend, predict the registered write, clock, compare.
  task automatic cycle();
    logic        force_a, lwin, pop, push;
    logic        e_rf_ena, e_time_ena;
    logic [4:0]  e_rdidx;
    logic [31:0] e_wdat;
    logic [9:0]  e_twdat;
    ent_t        h;
    #1;
    if (rst) begin
      @(posedge clk);
      #1;
      mq.delete();
      m_starve = 0;
      chk("rst_rf_ena", rf_ena, 0);
      chk("rst_rf_rdidx", rf_rdidx, 0);
      chk("rst_rf_wdat", rf_wdat, 0);
      chk("rst_time_ena", time_ena, 0);
      chk("rst_time_wdat", time_wdat, 0);
      chk("rst_pend", pend, 0);
      chk("rst_alu_ready", alu_if.ready, 1);
      return;
    end
    force_a = (m_starve == STARVE_MAX) && (mq.size() > 0);
    chk("alu_ready", alu_if.ready, mq.size() != DEPTH);
    chk("lng_ready", lng_if.ready, !force_a);
    chk("pend", pend, mq.size() != 0);
    lwin = lng_if.valid && !force_a;
    pop  = !lwin && (mq.size() > 0);
    push = alu_if.valid && (mq.size() != DEPTH);
    e_rf_ena = 1'b0; e_time_ena = 1'b0; e_rdidx = 5'd0; e_wdat = 32'd0; e_twdat = 10'd0;
    if (lwin) begin
      e_rf_ena = (lng_if.rdidx != 5'd0);
      e_rdidx  = lng_if.rdidx;
      e_wdat   = lng_if.wdat;
    end else if (pop) begin
      h = mq[0];
      if (h.is_time) begin
        e_time_ena = 1'b1;
        e_twdat    = h.wdat[9:0];
      end else begin
        e_rf_ena = (h.rdidx != 5'd0);
        e_rdidx  = h.rdidx;
        e_wdat   = h.wdat;
      end
    end
    if (pop || mq.size() == 0) m_starve = 0;
    else if (lwin && m_starve < STARVE_MAX) m_starve++;
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back('{alu_if.wdat, alu_if.rdidx, alu_if.is_time});
    @(posedge clk);
    #1;
    chk("rf_ena", rf_ena, e_rf_ena);
    chk("time_ena", time_ena, e_time_ena);
    if (e_rf_ena) begin
      chk("rf_rdidx", rf_rdidx, e_rdidx);
      chk("rf_wdat", rf_wdat, e_wdat);
    end
    if (e_time_ena) chk("time_wdat", time_wdat, e_twdat);
  endtask

  task automatic idle(input int n);
    alu_if.valid = 1'b0;
    lng_if.valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_alu(input logic v, input logic [31:0] d, input logic [4:0] r, input logic t);
    alu_if.valid = v; alu_if.wdat = d; alu_if.rdidx = r; alu_if.is_time = t;
  endtask

  task automatic set_lng(input logic v, input logic [31:0] d, input logic [4:0] r);
    lng_if.valid = v; lng_if.wdat = d; lng_if.rdidx = r;
  endtask

  initial begin
    vecs[0] = '{32'h0000_1234, 5'd3,  1'b0, 1'b1, 5'd3,  32'h0000_1234, 1'b0, 10'h000};
    vecs[1] = '{32'hFFFF_F7AB, 5'd7,  1'b1, 1'b0, 5'd0,  32'h0000_0000, 1'b1, 10'h3AB};
    vecs[2] = '{32'h0000_DEAD, 5'd0,  1'b0, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 10'h000};
    vecs[3] = '{32'hFFFF_FFFF, 5'd31, 1'b0, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0, 10'h000};
    vecs[4] = '{32'h0000_0400, 5'd0,  1'b1, 1'b0, 5'd0,  32'h0000_0000, 1'b1, 10'h000};
    vecs[5] = '{32'h0000_03FF, 5'd1,  1'b1, 1'b0, 5'd0,  32'h0000_0000, 1'b1, 10'h3FF};

    set_alu(1'b0, 32'd0, 5'd0, 1'b0);
    set_lng(1'b0, 32'd0, 5'd0);
    lng_if.is_time = 1'b0;
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    idle(2);

    // Single pushes from idle: write exactly two cycles after the push cycle.
    for (int i = 0; i < 6; i++) begin
      idle(2);
      set_alu(1'b1, vecs[i].wdat, vecs[i].rdidx, vecs[i].is_time);
      cycle();
      alu_if.valid = 1'b0;
      chk("vec_early_rf", rf_ena, 0);
      chk("vec_early_time", time_ena, 0);
      chk("vec_pend_hi", pend, 1);
      cycle();
      chk("vec_rf_ena", rf_ena, vecs[i].exp_rf_ena);
      chk("vec_time_ena", time_ena, vecs[i].exp_time_ena);
      if (vecs[i].exp_rf_ena) begin
        chk("vec_rf_rdidx", rf_rdidx, vecs[i].exp_rdidx);
        chk("vec_rf_wdat", rf_wdat, vecs[i].exp_rf_wdat);
      end
      if (vecs[i].exp_time_ena) chk("vec_time_wdat", time_wdat, vecs[i].exp_time_wdat);
      chk("vec_pend_lo", pend, 0);
      cycle();
      chk("vec_once_rf", rf_ena, 0);
      chk("vec_once_time", time_ena, 0);
    end

    // Three pushes while the long pipe holds the slot: FIFO fills, third waits, order kept.
    idle(2);
    set_lng(1'b1, 32'h0000_0AAA, 5'd2);
    set_alu(1'b1, 32'h0000_0111, 5'd1, 1'b0);
    cycle();
    set_alu(1'b1, 32'h0000_0222, 5'd4, 1'b0);
    cycle();
    chk("b2b_ready_lo", alu_if.ready, 0);
    set_lng(1'b0, 32'd0, 5'd0);
    set_alu(1'b1, 32'h0000_0333, 5'd5, 1'b0);
    cycle();
    chk("b2b_first", rf_wdat, 32'h0000_0111);
    chk("b2b_ready_hi", alu_if.ready, 1);
    cycle();
    chk("b2b_second", rf_wdat, 32'h0000_0222);
    alu_if.valid = 1'b0;
    cycle();
    chk("b2b_third", rf_wdat, 32'h0000_0333);
    chk("b2b_third_ena", rf_ena, 1);

    // Starvation guard: four long wins, then one forced ALU retire, then long resumes.
    idle(3);
    set_alu(1'b1, 32'hA5A5_0001, 5'd9, 1'b0);
    cycle();
    alu_if.valid = 1'b0;
    for (int i = 0; i < STARVE_MAX; i++) begin
      set_lng(1'b1, 32'hBEEF_0000 + i, 5'd10);
      chk("starve_lng_ready", lng_if.ready, 1);
      cycle();
      chk("starve_lng_write", rf_wdat, 32'hBEEF_0000 + i);
    end
    chk("starve_force", lng_if.ready, 0);
    cycle();
    chk("starve_alu_wdat", rf_wdat, 32'hA5A5_0001);
    chk("starve_alu_rdidx", rf_rdidx, 5'd9);
    chk("starve_resume", lng_if.ready, 1);
    set_lng(1'b1, 32'hBEEF_00FF, 5'd11);
    cycle();
    chk("starve_lng_again", rf_wdat, 32'hBEEF_00FF);

    // Reset with a full FIFO drops everything.
    idle(3);
    set_lng(1'b1, 32'h0000_0777, 5'd12);
    set_alu(1'b1, 32'h0000_0444, 5'd13, 1'b0);
    cycle();
    cycle();
    chk("rstmid_full", alu_if.ready, 0);
    set_alu(1'b0, 32'd0, 5'd0, 1'b0);
    set_lng(1'b0, 32'd0, 5'd0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rstmid_pend", pend, 0);
    chk("rstmid_ready", alu_if.ready, 1);
    cycle();
    chk("rstmid_no_rf", rf_ena, 0);
    chk("rstmid_no_time", time_ena, 0);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      set_alu(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)),
              1'($urandom_range(0, 3) == 0));
      set_lng(1'($urandom_range(0, 9) < 6), $urandom, 5'($urandom_range(0, 31)));
      cycle();
    end
    rst = 1'b0;
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
